n64_pi_bus_frontend: RTL and testbench

Upstream neighbour of the SDRAM controller on the dev cart. It decodes the N64 Parallel Interface cartridge bus (multiplexed AD16, ALEH/ALEL, /READ, /WRITE) into word requests on the controller's readport/writeport handshakes. It prefetches the next ROM word so the data is ready when /READ falls. It also returns read data onto the AD bus.

---
 rtl/n64_pi_pkg.sv | 27 ++
 rtl/n64_sig_sync.sv | 25 ++
 rtl/n64_pi_bus_frontend.sv | 187 ++++++++++++++++++
 tb/tb_n64_pi_bus_frontend.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/n64_pi_pkg.sv
// Shared constants and types for the N64 PI cartridge-bus frontend.
package n64_pi_pkg;

    localparam logic [31:0] PI_WINDOW_BASE = 32'h1000_0000;
    localparam logic [31:0] PI_WINDOW_MASK = 32'h01FF_FFFF;

    // Synchronized strobe vector layout: {aleh, alel, read_n, write_n}
    localparam int SYNC_W = 4;
    localparam int S_ALEH = 3;
    localparam int S_ALEL = 2;
    localparam int S_RD_N = 1;
    localparam int S_WR_N = 0;
    localparam logic [SYNC_W-1:0] SYNC_IDLE = 4'b0011;

    typedef enum logic [1:0] {
        P_IDLE,
        P_REQ,
        P_DISCARD
    } pf_state_e;

    function automatic logic win_hit(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [31:0] mask);
        return (addr & ~mask) == base;
    endfunction

endpackage

// File: rtl/n64_sig_sync.sv
// Multi-stage synchronizer for a vector of async strobes; each bit resets to its own idle level.
module n64_sig_sync #(
    parameter int               WIDTH   = 1,
    parameter int               STAGES  = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [STAGES-1:0][WIDTH-1:0] ff_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ff_q <= {STAGES{RST_VAL}};
        end else begin
            ff_q <= {ff_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = ff_q[STAGES-1];

endmodule

// File: rtl/n64_pi_bus_frontend.sv
// Decodes the N64 PI cartridge bus into SDRAM read/write port requests,
// prefetching the next ROM word so it is ready when /READ falls.
module n64_pi_bus_frontend
    import n64_pi_pkg::*;
#(
    parameter logic [31:0] WINDOW_BASE = PI_WINDOW_BASE,
    parameter logic [31:0] WINDOW_MASK = PI_WINDOW_MASK,
    parameter bit          WRITE_EN    = 1'b1,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] n64_ad_in,
    output logic [15:0] n64_ad_out,
    output logic        n64_ad_oe,
    input  logic        n64_aleh,
    input  logic        n64_alel,
    input  logic        n64_read_n,
    input  logic        n64_write_n,
    output logic        readport_rd,
    output logic [31:0] readport_addr,
    input  logic [15:0] readport_data,
    input  logic        readport_ack,
    output logic        writeport_wr,
    output logic [31:0] writeport_addr,
    output logic [15:0] writeport_data,
    input  logic        writeport_ack,
    output logic        err_underrun,
    output logic        err_overrun
);

    logic [SYNC_W-1:0] bus_s, bus_prev_q;

    n64_sig_sync #(
        .WIDTH  (SYNC_W),
        .STAGES (SYNC_STAGES),
        .RST_VAL(SYNC_IDLE)
    ) u_sync (
        .clk_i (clk),
        .rst_ni(rst),
        .d_i   ({n64_aleh, n64_alel, n64_read_n, n64_write_n}),
        .q_o   (bus_s)
    );

    logic aleh_fall, alel_fall, rd_fall, rd_rise, wr_rise, wr_evt;
    logic hi_latch, pf_kick, stale, hit;

    assign aleh_fall = bus_prev_q[S_ALEH] & ~bus_s[S_ALEH];
    assign alel_fall = bus_prev_q[S_ALEL] & ~bus_s[S_ALEL];
    assign rd_fall   = bus_prev_q[S_RD_N] & ~bus_s[S_RD_N];
    assign rd_rise   = ~bus_prev_q[S_RD_N] & bus_s[S_RD_N];
    assign wr_rise   = ~bus_prev_q[S_WR_N] & bus_s[S_WR_N];
    // A write strobe overlapping any read activity is illegal on PI and ignored.
    assign wr_evt    = WRITE_EN && wr_rise && bus_s[S_RD_N] && bus_prev_q[S_RD_N];
    assign hi_latch  = aleh_fall & bus_s[S_ALEL];
    assign pf_kick   = alel_fall | rd_rise | wr_evt;
    assign stale     = hi_latch | pf_kick;

    logic [31:0] addr_q, addr_d, rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
    logic [15:0] buf_q, buf_d, wr_data_q, wr_data_d, ad_out_q, ad_out_d;
    logic        buf_vld_q, buf_vld_d, pend_q, pend_d, wr_pend_q, wr_pend_d;
    logic        oe_q, oe_d, ur_q, ur_d, or_q, or_d;
    pf_state_e   pf_q, pf_d;

    assign hit = win_hit(addr_q, WINDOW_BASE, WINDOW_MASK);

    always_comb begin
        addr_d    = addr_q;
        buf_d     = buf_q;
        buf_vld_d = buf_vld_q;
        pf_d      = pf_q;
        pend_d    = pend_q;
        rd_addr_d = rd_addr_q;
        wr_pend_d = wr_pend_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        oe_d      = oe_q;
        ad_out_d  = ad_out_q;
        ur_d      = ur_q;
        or_d      = or_q;

        if (rd_rise || wr_evt) addr_d = addr_q + 32'd2;
        if (hi_latch)          addr_d[31:16] = n64_ad_in;
        if (alel_fall)         addr_d[15:0]  = {n64_ad_in[15:1], 1'b0};
        if (pf_kick) begin
            buf_vld_d = 1'b0;
            pend_d    = 1'b1;
        end

        // Launch waits for a quiet cycle so it sees the settled address,
        // and for any pending write so the read observes written data.
        case (pf_q)
            P_IDLE: begin
                if (pend_q && !wr_pend_q && !stale) begin
                    pend_d = 1'b0;
                    if (hit) begin
                        pf_d      = P_REQ;
                        rd_addr_d = addr_q & WINDOW_MASK;
                    end
                end
            end
            P_REQ: begin
                if (readport_ack) begin
                    pf_d = P_IDLE;
                    if (!stale) begin
                        buf_d     = readport_data;
                        buf_vld_d = 1'b1;
                    end
                end else if (stale) begin
                    pf_d = P_DISCARD;
                end
            end
            P_DISCARD: begin
                if (readport_ack) pf_d = P_IDLE;
            end
            default: pf_d = P_IDLE;
        endcase

        if (rd_fall && hit) begin
            oe_d = 1'b1;
            if (buf_vld_q) begin
                ad_out_d = buf_q;
            end else begin
                ad_out_d = 16'hFFFF;
                ur_d     = 1'b1;
            end
        end
        if (rd_rise) oe_d = 1'b0;

        if (writeport_ack) wr_pend_d = 1'b0;
        if (wr_evt && hit) begin
            if (wr_pend_q) begin
                or_d = 1'b1;
            end else begin
                wr_pend_d = 1'b1;
                wr_addr_d = addr_q & WINDOW_MASK;
                wr_data_d = n64_ad_in;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_prev_q <= SYNC_IDLE;
            addr_q     <= '0;
            buf_q      <= '0;
            buf_vld_q  <= 1'b0;
            pf_q       <= P_IDLE;
            pend_q     <= 1'b0;
            rd_addr_q  <= '0;
            wr_pend_q  <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            oe_q       <= 1'b0;
            ad_out_q   <= '0;
            ur_q       <= 1'b0;
            or_q       <= 1'b0;
        end else begin
            bus_prev_q <= bus_s;
            addr_q     <= addr_d;
            buf_q      <= buf_d;
            buf_vld_q  <= buf_vld_d;
            pf_q       <= pf_d;
            pend_q     <= pend_d;
            rd_addr_q  <= rd_addr_d;
            wr_pend_q  <= wr_pend_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            oe_q       <= oe_d;
            ad_out_q   <= ad_out_d;
            ur_q       <= ur_d;
            or_q       <= or_d;
        end
    end

    // A write held behind an in-flight prefetch is presented only once that read retires.
    assign readport_rd    = (pf_q != P_IDLE);
    assign readport_addr  = rd_addr_q;
    assign writeport_wr   = wr_pend_q && (pf_q == P_IDLE);
    assign writeport_addr = wr_addr_q;
    assign writeport_data = wr_data_q;
    assign n64_ad_oe      = oe_q;
    assign n64_ad_out     = ad_out_q;
    assign err_underrun   = ur_q;
    assign err_overrun    = or_q;

endmodule

// File: tb/tb_n64_pi_bus_frontend.sv
// Randomized scoreboard bench for the PI bus frontend with an SDRAM port responder.
module tb_n64_pi_bus_frontend;

    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] n64_ad_in = '0;
    logic [15:0] n64_ad_out;
    logic        n64_ad_oe;
    logic        n64_aleh = 1'b0, n64_alel = 1'b0;
    logic        n64_read_n = 1'b1, n64_write_n = 1'b1;
    logic        readport_rd, writeport_wr;
    logic [31:0] readport_addr, writeport_addr;
    logic [15:0] readport_data, writeport_data;
    logic        readport_ack, writeport_ack;
    logic        err_underrun, err_overrun;

    always #5 clk = ~clk;

    n64_pi_bus_frontend dut (
        .clk(clk), .rst(rst),
        .n64_ad_in(n64_ad_in), .n64_ad_out(n64_ad_out), .n64_ad_oe(n64_ad_oe),
        .n64_aleh(n64_aleh), .n64_alel(n64_alel),
        .n64_read_n(n64_read_n), .n64_write_n(n64_write_n),
        .readport_rd(readport_rd), .readport_addr(readport_addr),
        .readport_data(readport_data), .readport_ack(readport_ack),
        .writeport_wr(writeport_wr), .writeport_addr(writeport_addr),
        .writeport_data(writeport_data), .writeport_ack(writeport_ack),
        .err_underrun(err_underrun), .err_overrun(err_overrun)
    );

    int errors = 0;
    int checks = 0;
    int unsigned rd_lat = 4;
    int unsigned wr_lat = 3;

    logic [15:0] sd_mem  [int unsigned];
    logic [15:0] ref_mem [int unsigned];

    typedef struct packed {
        logic [31:0] a;
        logic [15:0] d;
    } wr_t;

    logic [31:0] exp_rd_q[$];
    wr_t         exp_wr_q[$];
    logic [15:0] exp_ad_q[$];

    logic [31:0] m_addr = '0;
    logic        m_ur = 1'b0;
    logic        m_or = 1'b0;

    function automatic logic [15:0] dflt(input logic [31:0] off);
        return off[16:1] ^ 16'hC3A5;
    endfunction

    function automatic logic [15:0] sd_rd(input logic [31:0] off);
        return sd_mem.exists(off) ? sd_mem[off] : dflt(off);
    endfunction

    function automatic logic [15:0] ref_rd(input logic [31:0] off);
        return ref_mem.exists(off) ? ref_mem[off] : dflt(off);
    endfunction

    // 32 MB ROM window starting at 0x1000_0000
    function automatic bit hit(input logic [31:0] a);
        return (a >= BASE) && (a <= 32'h11FF_FFFF);
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic poke(input logic [31:0] off, input logic [15:0] v);
        sd_mem[off]  = v;
        ref_mem[off] = v;
    endtask

    task automatic ale(input logic [31:0] a);
        n64_aleh = 1'b1; n64_alel = 1'b1; n64_ad_in = a[31:16];
        cyc(6);
        n64_aleh = 1'b0;
        cyc(6);
        n64_ad_in = a[15:0];
        cyc(6);
        m_addr = {a[31:1], 1'b0};
        if (hit(m_addr)) exp_rd_q.push_back(m_addr - BASE);
        n64_alel = 1'b0;
        cyc(6);
    endtask

    task automatic pi_read(input int hold, input bit underrun);
        logic h;
        h = hit(m_addr);
        if (h) begin
            if (underrun) begin
                exp_ad_q.push_back(16'hFFFF);
                m_ur = 1'b1;
            end else begin
                exp_ad_q.push_back(ref_rd(m_addr - BASE));
            end
        end
        n64_read_n = 1'b0;
        cyc(hold);
        if (!h) begin
            check("miss_oe", {31'd0, n64_ad_oe}, 32'd0);
            check("miss_rd", {31'd0, readport_rd}, 32'd0);
        end
        m_addr = m_addr + 32'd2;
        if (hit(m_addr)) exp_rd_q.push_back(m_addr - BASE);
        n64_read_n = 1'b1;
        cyc(10);
    endtask

    task automatic pi_write(input logic [15:0] d, input bit drop, input bit pf);
        wr_t w;
        if (hit(m_addr)) begin
            if (drop) begin
                m_or = 1'b1;
            end else begin
                w.a = m_addr - BASE;
                w.d = d;
                exp_wr_q.push_back(w);
                ref_mem[m_addr - BASE] = d;
            end
        end
        n64_ad_in   = d;
        n64_write_n = 1'b0;
        cyc(6);
        m_addr = m_addr + 32'd2;
        if (pf && hit(m_addr)) exp_rd_q.push_back(m_addr - BASE);
        n64_write_n = 1'b1;
        cyc(6);
    endtask

    // SDRAM controller stand-in: fixed-latency ack per request, latency latched at start
    initial begin : sdram
        bit rb, wb;
        int unsigned rc, wc, rl, wl;
        logic [31:0] ra, wa;
        logic [15:0] wd;
        rb = 0; wb = 0; rc = 0; wc = 0; rl = 0; wl = 0; ra = '0; wa = '0; wd = '0;
        readport_ack = 1'b0; writeport_ack = 1'b0; readport_data = '0;
        forever begin
            @(posedge clk);
            #1;
            readport_ack  = 1'b0;
            writeport_ack = 1'b0;
            if (!rst) begin
                rb = 0;
                wb = 0;
            end else begin
                if (rb) begin
                    rc++;
                    if (rc >= rl) begin
                        readport_ack  = 1'b1;
                        readport_data = sd_rd(ra);
                        rb = 0;
                    end
                end else if (readport_rd) begin
                    rb = 1; rc = 0; rl = rd_lat; ra = readport_addr;
                end
                if (wb) begin
                    wc++;
                    if (wc >= wl) begin
                        writeport_ack = 1'b1;
                        sd_mem[wa] = wd;
                        wb = 0;
                    end
                end else if (writeport_wr) begin
                    wb = 1; wc = 0; wl = wr_lat; wa = writeport_addr; wd = writeport_data;
                end
            end
        end
    end

    // Monitor: every new request / bus drive is matched against the scoreboard
    initial begin : monitor
        logic prd, pwr, poe;
        wr_t  w;
        prd = 1'b0; pwr = 1'b0; poe = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (readport_rd && writeport_wr) begin
                    errors++;
                    $display("FAIL rd_wr_overlap: rd=%0b wr=%0b, required never both", readport_rd, writeport_wr);
                end
                if (readport_rd && !prd) begin
                    if (exp_rd_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL rd_unexpected: addr %0h issued, none expected", readport_addr);
                    end else begin
                        check("rd_addr", readport_addr, exp_rd_q.pop_front());
                    end
                end
                if (writeport_wr && !pwr) begin
                    if (exp_wr_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL wr_unexpected: addr %0h data %0h, none expected", writeport_addr, writeport_data);
                    end else begin
                        w = exp_wr_q.pop_front();
                        check("wr_addr", writeport_addr, w.a);
                        check("wr_data", {16'd0, writeport_data}, {16'd0, w.d});
                    end
                end
                if (n64_ad_oe && !poe) begin
                    if (exp_ad_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL ad_unexpected: bus driven with %0h, no drive expected", n64_ad_out);
                    end else begin
                        check("ad_data", {16'd0, n64_ad_out}, {16'd0, exp_ad_q.pop_front()});
                    end
                end
            end
            prd = readport_rd;
            pwr = writeport_wr;
            poe = n64_ad_oe;
        end
    end

    initial begin : watchdog
        #1_000_000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int unsigned r;
        logic [31:0] a;

        cyc(3);
        check("rst_rd", {31'd0, readport_rd}, 32'd0);
        check("rst_wr", {31'd0, writeport_wr}, 32'd0);
        check("rst_oe", {31'd0, n64_ad_oe}, 32'd0);
        check("rst_err", {30'd0, err_underrun, err_overrun}, 32'd0);
        rst = 1'b1;
        cyc(3);

        // single read with 4-cycle SDRAM latency
        poke(32'h0, 16'hABCD);
        rd_lat = 4;
        ale(32'h1000_0000);
        cyc(10);
        pi_read(6, 1'b0);
        cyc(12);

        // 4-word burst, 2-cycle latency
        poke(32'h0, 16'h1111); poke(32'h2, 16'h2222);
        poke(32'h4, 16'h3333); poke(32'h6, 16'h4444);
        rd_lat = 2;
        ale(32'h1000_0000);
        cyc(6);
        for (int i = 0; i < 4; i++) pi_read(6, 1'b0);
        check("burst_underrun", {31'd0, err_underrun}, 32'd0);

        // outside the window: no request, no drive
        rd_lat = 4;
        ale(32'h0500_0000);
        cyc(6);
        pi_read(6, 1'b0);

        // write, then a dropped write behind a slow ack
        wr_lat = 3;
        ale(32'h1000_0010);
        cyc(10);
        pi_write(16'hBEEF, 1'b0, 1'b1);
        cyc(12);
        check("ovr_clear", {31'd0, err_overrun}, 32'd0);
        wr_lat = 40;
        pi_write(16'h1234, 1'b0, 1'b0);
        pi_write(16'h5678, 1'b1, 1'b1);
        cyc(50);
        check("ovr_set", {31'd0, err_overrun}, 32'd1);
        wr_lat = 3;
        ale(32'h1000_0010);
        cyc(10);
        for (int i = 0; i < 3; i++) pi_read(6, 1'b0);

        // re-address while a slow prefetch is in flight
        rd_lat = 30;
        ale(32'h1000_0100);
        ale(32'h1000_0200);
        rd_lat = 4;
        cyc(80);
        pi_read(6, 1'b0);

        // walk off the end of the window
        rd_lat = 3;
        ale(32'h11FF_FFFC);
        cyc(10);
        for (int i = 0; i < 3; i++) pi_read(6, 1'b0);

        // randomized mix of address phases, reads and writes
        for (int i = 0; i < 30; i++) begin
            rd_lat = $urandom_range(1, 8);
            wr_lat = $urandom_range(1, 8);
            r = $urandom_range(0, 9);
            if (r < 2) begin
                if ($urandom_range(0, 5) == 0) a = 32'h0800_0000 | ($urandom & 32'h00FF_FFFE);
                else a = BASE + 32'($urandom_range(0, 63) * 2);
                ale(a);
            end else if (r < 7) begin
                pi_read(6, 1'b0);
            end else begin
                pi_write(16'($urandom), 1'b0, 1'b1);
            end
            cyc(20);
        end
        check("rand_ur", {31'd0, err_underrun}, {31'd0, m_ur});

        // slow ack: /READ falls before data arrives
        rd_lat = 40;
        ale(32'h1000_0040);
        rd_lat = 4;
        pi_read(45, 1'b1);
        check("ur_set", {31'd0, err_underrun}, 32'd1);
        cyc(12);
        pi_read(6, 1'b0);
        check("ur_sticky", {31'd0, err_underrun}, 32'd1);
        check("or_model", {31'd0, err_overrun}, {31'd0, m_or});

        // async reset mid-transaction
        rd_lat = 30;
        ale(32'h1000_0000);
        exp_ad_q.push_back(16'hFFFF);
        n64_read_n = 1'b0;
        cyc(6);
        check("pre_rst_rd", {31'd0, readport_rd}, 32'd1);
        check("pre_rst_oe", {31'd0, n64_ad_oe}, 32'd1);
        #1 rst = 1'b0;
        #1;
        check("arst_rd", {31'd0, readport_rd}, 32'd0);
        check("arst_oe", {31'd0, n64_ad_oe}, 32'd0);
        check("arst_ad", {16'd0, n64_ad_out}, 32'd0);
        check("arst_raddr", readport_addr, 32'd0);
        check("arst_err", {30'd0, err_underrun, err_overrun}, 32'd0);
        m_ur = 1'b0; m_or = 1'b0;
        n64_read_n = 1'b1;
        cyc(3);
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            if (readport_rd || n64_ad_oe || writeport_wr) begin
                errors++;
                $display("FAIL post_rst_idle: rd=%0b oe=%0b wr=%0b, required all 0", readport_rd, n64_ad_oe, writeport_wr);
            end
        end
        checks++;

        check("q_rd_empty", exp_rd_q.size(), 32'd0);
        check("q_wr_empty", exp_wr_q.size(), 32'd0);
        check("q_ad_empty", exp_ad_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
